// File: rtl/avst_colour_bar_tpg.sv
// Avalon-ST Video test pattern source: control packet + video packet per frame,
// 24-bit RGB, four patterns (bars, ramp, checker, white).
module avst_colour_bar_tpg #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        dout_ready,
  output logic        dout_valid,
  output logic [23:0] dout_data,
  output logic        dout_startofpacket,
  output logic        dout_endofpacket,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned BAR_W    = WIDTH / 8;
  localparam logic [15:0] W16      = 16'(WIDTH);
  localparam logic [15:0] H16      = 16'(HEIGHT);
  localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
  localparam logic [15:0] RUN_LAST = 16'(BAR_W - 1);

  typedef enum logic [2:0] {
    IDLE, CTRL_HDR, CTRL_0, CTRL_1, CTRL_2, VID_HDR, PIXEL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, run_q, run_d;
  logic [2:0]  bar_q, bar_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] count_d;
  logic [23:0] data_d;
  logic        valid_d, sop_d, eop_d, busy_d;
  logic        advance;

  // Colour of one pixel for the latched pattern
  function automatic logic [23:0] pixel_rgb(input logic [1:0] m, input logic [7:0] px8,
                                            input logic px5, input logic py5,
                                            input logic [2:0] b);
    logic [23:0] rgb;
    rgb = 24'hFFFFFF;
    case (m)
      2'd0: begin
        case (b)
          3'd0:    rgb = 24'hFFFFFF;
          3'd1:    rgb = 24'hFFFF00;
          3'd2:    rgb = 24'h00FFFF;
          3'd3:    rgb = 24'h00FF00;
          3'd4:    rgb = 24'hFF00FF;
          3'd5:    rgb = 24'hFF0000;
          3'd6:    rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      2'd1:    rgb = {px8, px8, px8};
      2'd2:    rgb = (px5 ^ py5) ? 24'hFFFFFF : 24'h000000;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

  // Next beat: advance on acceptance (IDLE always evaluates), else hold
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    bar_d   = bar_q;
    mode_d  = mode_q;
    count_d = frame_count;
    valid_d = dout_valid;
    data_d  = dout_data;
    sop_d   = dout_startofpacket;
    eop_d   = dout_endofpacket;
    advance = (state_q == IDLE) || dout_ready;

    if (advance) begin
      valid_d = 1'b1;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      data_d  = 24'h000000;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = CTRL_HDR;
            mode_d  = mode;
            data_d  = 24'h00000F;
            sop_d   = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        CTRL_HDR: begin
          state_d = CTRL_0;
          data_d  = {4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
        end
        CTRL_0: begin
          state_d = CTRL_1;
          data_d  = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
        end
        CTRL_1: begin
          state_d = CTRL_2;
          data_d  = {4'h0, 4'h3, 4'h0, H16[3:0], 4'h0, H16[7:4]};
          eop_d   = 1'b1;
        end
        CTRL_2: begin
          state_d = VID_HDR;
          sop_d   = 1'b1;
        end
        VID_HDR: begin
          state_d = PIXEL;
          x_d     = 16'd0;
          y_d     = 16'd0;
          run_d   = 16'd0;
          bar_d   = 3'd0;
          data_d  = pixel_rgb(mode_q, 8'd0, 1'b0, 1'b0, 3'd0);
        end
        PIXEL: begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            count_d = frame_count + 16'd1;
            if (enable) begin
              state_d = CTRL_HDR;
              mode_d  = mode;
              data_d  = 24'h00000F;
              sop_d   = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end else begin
            if (x_q == X_LAST) begin
              x_d   = 16'd0;
              y_d   = y_q + 16'd1;
              run_d = 16'd0;
              bar_d = 3'd0;
            end else begin
              x_d = x_q + 16'd1;
              // Run counter replaces x / (WIDTH/8); bar 7 soaks up the remainder
              if (run_q == RUN_LAST && bar_q != 3'd7) begin
                run_d = 16'd0;
                bar_d = bar_q + 3'd1;
              end else begin
                run_d = run_q + 16'd1;
              end
            end
            data_d = pixel_rgb(mode_q, x_d[7:0], x_d[5], y_d[5], bar_d);
            eop_d  = (x_d == X_LAST) && (y_d == Y_LAST);
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      x_q                <= 16'd0;
      y_q                <= 16'd0;
      run_q              <= 16'd0;
      bar_q              <= 3'd0;
      mode_q             <= 2'd0;
      frame_count        <= 16'd0;
      dout_valid         <= 1'b0;
      dout_data          <= 24'h000000;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      x_q                <= x_d;
      y_q                <= y_d;
      run_q              <= run_d;
      bar_q              <= bar_d;
      mode_q             <= mode_d;
      frame_count        <= count_d;
      dout_valid         <= valid_d;
      dout_data          <= data_d;
      dout_startofpacket <= sop_d;
      dout_endofpacket   <= eop_d;
      busy               <= busy_d;
    end
  end

endmodule

// File: tb/tb_avst_colour_bar_tpg.sv
// Directed bench for avst_colour_bar_tpg: 16x4 instance for most cases, 64x2 for the checker case.
`timescale 1ns/1ps
module tb_avst_colour_bar_tpg;

  localparam int EV_NONE = 0;
  localparam int EV_MODE = 1;
  localparam int EV_ENA  = 2;

  logic        clk = 1'b0;
  logic        reset, enable, ready, sel;
  logic [1:0]  mode;

  logic        v16, s16, e16, b16, v64, s64, e64, b64;
  logic [23:0] d16, d64;
  logic [15:0] fc16, fc64;

  logic        valid, sop, eop, busy;
  logic [23:0] data;
  logic [15:0] fcount;

  typedef struct packed {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t beats[$];
  beat_t ref_beats[$];
  int    n_checks = 0;
  int    n_errors = 0;

  avst_colour_bar_tpg #(.WIDTH(16), .HEIGHT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dout_ready(ready),
    .dout_valid(v16), .dout_data(d16), .dout_startofpacket(s16),
    .dout_endofpacket(e16), .frame_count(fc16), .busy(b16)
  );

  avst_colour_bar_tpg #(.WIDTH(64), .HEIGHT(2)) dut_w64 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dout_ready(ready),
    .dout_valid(v64), .dout_data(d64), .dout_startofpacket(s64),
    .dout_endofpacket(e64), .frame_count(fc64), .busy(b64)
  );

  always #5 clk = ~clk;

  // Observe the selected instance
  always_comb begin
    valid  = sel ? v64  : v16;
    data   = sel ? d64  : d16;
    sop    = sel ? s64  : s16;
    eop    = sel ? e64  : e16;
    busy   = sel ? b64  : b16;
    fcount = sel ? fc64 : fc16;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int i);
    beat_t b;
    b = (i < beats.size()) ? beats[i] : '0;
    return 32'(b.data);
  endfunction

  function automatic logic [31:0] word(input int i);
    beat_t b;
    b = (i < beats.size()) ? beats[i] : '0;
    return 32'(b);
  endfunction

  // Collect one frame (up to the video-packet eop), checking stalled beats hold
  task automatic collect_frame(input bit bp, input int ev_at, input int ev_kind,
                               input logic [1:0] ev_mode);
    logic [26:0] prev;
    bit          prev_stall;
    bit          done;
    int          cyc;
    beats.delete();
    prev       = '0;
    prev_stall = 1'b0;
    done       = 1'b0;
    cyc        = 0;
    while (!done && cyc < 5000) begin
      ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall)
        check("stall_hold", {5'b0, valid, sop, eop, data}, {5'b0, prev});
      if (valid && ready) begin
        beats.push_back({data, sop, eop});
        if (beats.size() == ev_at) begin
          if (ev_kind == EV_MODE) mode = ev_mode;
          else if (ev_kind == EV_ENA) enable = 1'b0;
        end
        if (eop && beats.size() > 5) done = 1'b1;
      end
      prev       = {valid, sop, eop, data};
      prev_stall = valid && !ready;
      @(negedge clk);
      cyc++;
    end
    if (!done) check("frame_timeout", 32'(done), 32'd1);
    ready = 1'b1;
  endtask

  task automatic restart(input bit s, input logic [1:0] m);
    sel    = s;
    reset  = 1'b1;
    enable = 1'b0;
    mode   = m;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; enable = 1'b0; ready = 1'b1; mode = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_sop",   32'(sop),   32'd0);
    check("rst_eop",   32'(eop),   32'd0);
    check("rst_fcount", 32'(fcount), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(valid), 32'd0);

    // One-cycle start latency
    enable = 1'b1;
    @(negedge clk);
    check("start_valid", 32'(valid), 32'd1);
    check("start_hdr",   32'(data),  32'h00000F);
    check("start_sop",   32'(sop),   32'd1);
    check("start_busy",  32'(busy),  32'd1);

    // Frame 1: bars; mode set to ramp mid-frame must not affect it
    collect_frame(1'b0, 20, EV_MODE, 2'd1);
    ref_beats = beats;
    check("f1_len",   32'(beats.size()), 32'd69);
    check("f1_ctrlh", word(0), {6'b0, 24'h00000F, 1'b1, 1'b0});
    check("f1_ctrl0", word(1), {6'b0, 24'h010000, 1'b0, 1'b0});
    check("f1_ctrl1", word(2), {6'b0, 24'h000000, 1'b0, 1'b0});
    check("f1_ctrl2", word(3), {6'b0, 24'h030400, 1'b0, 1'b1});
    check("f1_vidh",  word(4), {6'b0, 24'h000000, 1'b1, 1'b0});
    check("bar_x0",   pix(5),  32'hFFFFFF);
    check("bar_x1",   pix(6),  32'hFFFFFF);
    check("bar_x2",   pix(7),  32'hFFFF00);
    check("bar_x14",  pix(19), 32'h000000);
    check("bar_x15",  pix(20), 32'h000000);
    check("bar_y1x2", pix(23), 32'hFFFF00);
    check("bar_y3x9", pix(62), 32'hFF00FF);
    check("pix0_sop", word(5) & 32'h2, 32'h0);
    check("f1_eop",   word(68), {6'b0, 24'h000000, 1'b0, 1'b1});
    check("f1_pre_eop", word(67) & 32'h1, 32'h0);
    check("f1_fcount", 32'(fcount), 32'd1);
    check("b2b_valid", 32'(valid), 32'd1);
    check("b2b_hdr",  {7'b0, sop, data}, {7'b0, 1'b1, 24'h00000F});

    // Frame 2: ramp
    collect_frame(1'b0, 10, EV_MODE, 2'd3);
    check("f2_len",    32'(beats.size()), 32'd69);
    check("ramp_x5",   pix(10), 32'h050505);
    check("ramp_y1x7", pix(28), 32'h070707);
    check("ramp_last", pix(68), 32'h0F0F0F);

    // Frame 3: white
    collect_frame(1'b0, 0, EV_NONE, 2'd0);
    check("white_x0",  pix(5),  32'hFFFFFF);
    check("white_mid", pix(40), 32'hFFFFFF);
    check("f3_fcount", 32'(fcount), 32'd3);

    // Backpressure: same beats as the unstalled bars frame
    restart(1'b0, 2'd0);
    collect_frame(1'b1, 0, EV_NONE, 2'd0);
    check("bp_len", 32'(beats.size()), 32'd69);
    for (int i = 0; i < 69; i++)
      check($sformatf("bp_beat%0d", i), word(i),
            (i < ref_beats.size()) ? 32'(ref_beats[i]) : 32'hDEAD);
    check("bp_fcount", 32'(fcount), 32'd1);

    // Mode latch on 64x2: bars frame, then checker frame
    restart(1'b1, 2'd0);
    collect_frame(1'b0, 40, EV_MODE, 2'd2);
    check("w64_len",   32'(beats.size()), 32'd133);
    check("w64_ctrl0", word(1), {6'b0, 24'h040000, 1'b0, 1'b0});
    check("w64_ctrl2", word(3), {6'b0, 24'h030200, 1'b0, 1'b1});
    check("w64_bar_x0",  pix(5),  32'hFFFFFF);
    check("w64_bar_x32", pix(37), 32'hFF00FF);
    check("w64_bar_x63", pix(68), 32'h000000);
    collect_frame(1'b0, 0, EV_NONE, 2'd0);
    check("chk_x0",    pix(5),   32'h000000);
    check("chk_x31",   pix(36),  32'h000000);
    check("chk_x32",   pix(37),  32'hFFFFFF);
    check("chk_y1x32", pix(101), 32'hFFFFFF);
    check("w64_fcount", 32'(fcount), 32'd2);

    // Enable dropped mid-frame: frame completes, then idle
    restart(1'b0, 2'd3);
    collect_frame(1'b0, 10, EV_ENA, 2'd0);
    check("ena_len",   32'(beats.size()), 32'd69);
    check("ena_eop",   word(68) & 32'h1, 32'h1);
    check("ena_valid", 32'(valid), 32'd0);
    check("ena_busy",  32'(busy),  32'd0);
    check("ena_fcount", 32'(fcount), 32'd1);
    repeat (3) @(negedge clk);
    check("ena_idle", 32'(valid), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("ena_restart", {6'b0, valid, sop, data}, {6'b0, 1'b1, 1'b1, 24'h00000F});

    // Reset mid-pixel: asynchronous clear, restart with control header
    repeat (20) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_fcount", 32'(fcount), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_data",  32'(data),  32'd0);
    check("arst_sopeop", {30'b0, sop, eop}, 32'd0);
    check("arst_fcount", 32'(fcount), 32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_hdr", {6'b0, valid, sop, data}, {6'b0, 1'b1, 1'b1, 24'h00000F});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
